cam_capture_fifo: RTL

Parametrised camera capture front end: generates the sensor master clock (xclk) and power-down, oversamples the sensor's pclk/href/vsync/data bus in the system clock domain, assembles multi-byte pixels, and buffers them in a first-word-fall-through FIFO for the downstream frame-buffer/colour-detection logic. Next-generation successor to the fixed 8-bit divide/capture unit: configurable xclk ratio, bytes per pixel and FIFO depth, plus frame-level sequencing, overflow reporting and optional 2x2 decimation.

---
 rtl/cam_capture_fifo.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/cam_capture_fifo.sv
// Camera capture front end: xclk/pwdn generation, oversampled sensor bus, pixel assembly, FWFT FIFO.
// Optional 2x2 decimation is enabled by defining CAM_DECIMATE_EN.
module cam_capture_fifo #(
  parameter int unsigned DIV           = 4,
  parameter int unsigned BYTES_PER_PIX = 2,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         capture,
  input  logic                         vsync,
  input  logic                         href,
  input  logic                         pclk,
  input  logic [7:0]                   data_in,
  output logic                         xclk,
  output logic                         pwdn,
  input  logic                         rd_en,
  output logic [8*BYTES_PER_PIX-1:0]   pix_data,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int unsigned PIX_W = 8 * BYTES_PER_PIX;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned XW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned BW    = $clog2(BYTES_PER_PIX) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

  state_t state, state_nxt;
  logic   frame_done_nxt, ov_clr;

  logic [1:0]  pclk_s, href_s, vs_s;
  logic        pclk_d, href_d, vs_d;
  logic [7:0]  data_s1, data_s2;
  logic        capture_r;
  logic [XW-1:0] xcnt;

  logic [BW-1:0]    byte_cnt;
  logic [PIX_W-1:0] asm_q;
  logic             pix_vld;

  logic [PIX_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             we, re;

  logic pclk_rise, href_fall, vs_rise, vs_fall;
  assign pclk_rise = pclk_s[1] & ~pclk_d;
  assign href_fall = href_d & ~href_s[1];
  assign vs_rise   = vs_s[1] & ~vs_d;
  assign vs_fall   = vs_d & ~vs_s[1];

  // Two-flop synchronisers plus previous-value flops for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pclk_s    <= '0;
      href_s    <= '0;
      vs_s      <= '0;
      pclk_d    <= 1'b0;
      href_d    <= 1'b0;
      vs_d      <= 1'b0;
      data_s1   <= '0;
      data_s2   <= '0;
      capture_r <= 1'b0;
      pwdn      <= 1'b1;
    end else begin
      pclk_s    <= {pclk_s[0], pclk};
      href_s    <= {href_s[0], href};
      vs_s      <= {vs_s[0], vsync};
      pclk_d    <= pclk_s[1];
      href_d    <= href_s[1];
      vs_d      <= vs_s[1];
      data_s1   <= data_in;
      data_s2   <= data_s1;
      capture_r <= capture;
      pwdn      <= ~capture;
    end
  end

  // Free-running sensor master clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xcnt <= '0;
      xclk <= 1'b0;
    end else if (xcnt == XW'(HALF - 1)) begin
      xcnt <= '0;
      xclk <= ~xclk;
    end else begin
      xcnt <= xcnt + XW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    frame_done_nxt = 1'b0;
    ov_clr         = 1'b0;
    case (state)
      IDLE: begin
        if (capture_r) begin
          state_nxt = WAIT_VS;
          ov_clr    = 1'b1;
        end
      end
      WAIT_VS: begin
        if (!capture_r)   state_nxt = IDLE;
        else if (vs_fall) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (vs_rise) begin
          frame_done_nxt = 1'b1;
          state_nxt      = capture_r ? WAIT_VS : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= frame_done_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

`ifdef CAM_DECIMATE_EN
  logic col_par, line_par;

  // Column parity restarts each line, line parity each frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_par  <= 1'b0;
      line_par <= 1'b0;
    end else if (state != ACTIVE) begin
      col_par  <= 1'b0;
      line_par <= 1'b0;
    end else if (href_fall) begin
      col_par  <= 1'b0;
      line_par <= ~line_par;
    end else if (pclk_rise && href_s[1] && byte_cnt == BW'(BYTES_PER_PIX - 1)) begin
      col_par  <= ~col_par;
    end
  end

  logic keep;
  assign keep = ~col_par & ~line_par;
`else
  logic keep;
  assign keep = 1'b1;
`endif

  // Byte assembler: first byte shifts up into the MSBs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      asm_q    <= '0;
      pix_vld  <= 1'b0;
    end else begin
      pix_vld <= 1'b0;
      if (state != ACTIVE || href_fall) begin
        byte_cnt <= '0;
      end else if (pclk_rise && href_s[1]) begin
        asm_q <= PIX_W'({asm_q, data_s2});
        if (byte_cnt == BW'(BYTES_PER_PIX - 1)) begin
          byte_cnt <= '0;
          pix_vld  <= keep;
        end else begin
          byte_cnt <= byte_cnt + BW'(1);
        end
      end
    end
  end

  assign we     = pix_vld & ~full;
  assign re     = rd_en & ~empty;
  assign wr_nxt = wr_ptr + (AW+1)'(we);
  assign rd_nxt = rd_ptr + (AW+1)'(re);

  // FWFT FIFO; head is re-registered from the next read pointer, bypassing a write into an empty slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      pix_data <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (we) mem[wr_ptr[AW-1:0]] <= asm_q;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= ({~wr_nxt[AW], wr_nxt[AW-1:0]} == rd_nxt);
      if (we && wr_ptr[AW-1:0] == rd_nxt[AW-1:0]) pix_data <= asm_q;
      else                                         pix_data <= mem[rd_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                overflow <= 1'b0;
    else if (ov_clr)           overflow <= 1'b0;
    else if (pix_vld && full)  overflow <= 1'b1;
  end

endmodule
